// File: rtl/serial_arith_pkg.sv
// Shared definitions for the mux-based serial arithmetic blocks.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // 2:1 mux primitive; sel=0 passes in0, sel=1 passes in1.
    function automatic logic mux2(input logic sel, input logic in0, input logic in1);
        return sel ? in1 : in0;
    endfunction

endpackage

// File: rtl/fs_mux.sv
// One-bit full subtractor built only from 2:1 muxes: d = ai - bi - bin, bo = borrow out.
module fs_mux
    import serial_arith_pkg::*;
(
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic x;

    assign x  = mux2(bi, ai, ~ai);
    assign d  = mux2(bin, x, ~x);
    // Equal operand bits pass the incoming borrow; unequal bits borrow exactly when bi is set.
    assign bo = mux2(x, bin, bi);

endmodule

// File: rtl/serial_sub_mux.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock, start/done handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; diff/bout hold the last result
// S_SHIFT | one operand bit pair processed per clock, busy high
// S_DONE  | one-cycle done pulse; a new start is accepted here too
module serial_sub_mux
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bout_q, bout_d;

    logic               d_bit;
    logic               bo_bit;
    logic               last_bit;
    logic [WIDTH-1:0]   res_shift;

    fs_mux u_fs (
        .ai  (sa_q[0]),
        .bi  (sb_q[0]),
        .bin (borrow_q),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    assign res_shift = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bout_d   = bout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end else begin
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_SHIFT: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                res_d    = res_shift;
                borrow_d = bo_bit;
                // Counter parks at WIDTH-1 on the final bit; it is reloaded on the next start.
                if (last_bit) begin
                    diff_d  = res_shift;
                    bout_d  = bo_bit;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_mux.sv
// Scoreboard bench for serial_sub_mux: an 8-bit instance for directed/random work, a 4-bit one swept exhaustively.
module tb_serial_sub_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst8 = 1'b1, start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       busy8, done8, bout8;

    logic       rst4 = 1'b1, start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       busy4, done4, bout4;

    serial_sub_mux #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_mux #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    typedef struct {
        int unsigned diff;
        bit          bout;
        longint      cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_done4 = 0;

    int unsigned last8_diff = 0;
    bit          last8_bout = 1'b0;
    bit          rst_prev8 = 1'b1;
    always @(posedge clk) rst_prev8 <= rst8;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain modular subtraction and unsigned compare.
    function automatic exp_t model(input int w, input int unsigned a, input int unsigned b,
                                   input longint done_cyc);
        exp_t        e;
        int unsigned m;
        m          = 32'd1 << w;
        e.diff     = (a + m - b) % m;
        e.bout     = (a < b);
        e.cyc      = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_prev8) begin
            last8_diff = 0;
            last8_bout = 1'b0;
        end
        if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", done8, 0);
            end else begin
                e = q8.pop_front();
                chk("diff8", diff8, e.diff);
                chk("bout8", bout8, e.bout);
                chk("latency8", cyc, e.cyc);
                last8_diff = e.diff;
                last8_bout = e.bout;
            end
        end else begin
            chk("hold8", {bout8, diff8}, {last8_bout, last8_diff[7:0]});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                chk("unexpected_done4", done4, 0);
            end else begin
                e = q4.pop_front();
                chk("diff4", diff4, e.diff);
                chk("bout4", bout4, e.bout);
                chk("latency4", cyc, e.cyc);
                n_done4++;
            end
        end
    end

    // Called on a negedge where the DUT can accept; returns on the negedge of the done cycle.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit cb);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back(model(8, a, b, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cb) chk("busy8", busy8, 1);
            @(negedge clk);
        end
        if (cb) chk("busy8_end", busy8, 0);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        a4 = a; b4 = b; start4 = 1'b1;
        q4.push_back(model(4, a, b, cyc + 1 + 4));
        @(negedge clk);
        start4 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] oa, ob;

        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        rst4 = 1'b0;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_bout8", bout8, 0);
        @(negedge clk);

        issue8(8'h05, 8'h03, 1'b1);
        issue8(8'h03, 8'h05, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0);
        issue8(8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);

        // start held high: second operation accepted in the DONE cycle
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        q8.push_back(model(8, 8'h05, 8'h03, cyc + 1 + 8));
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h0F;
        q8.push_back(model(8, 8'hAA, 8'h0F, cyc + 17));
        repeat (9) @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        repeat (2) @(negedge clk);

        // start pulses and operand changes while shifting are ignored
        for (int r = 0; r < 3; r++) begin
            oa = 8'($urandom); ob = 8'($urandom);
            a8 = oa; b8 = ob; start8 = 1'b1;
            q8.push_back(model(8, oa, ob, cyc + 1 + 8));
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                start8 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom); b8 = 8'($urandom);
                @(negedge clk);
            end
            start8 = 1'b0;
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue8(8'($urandom), 8'($urandom), 1'b0);
        end
        @(negedge clk);
        issue8(8'h7B, 8'h21, 1'b0);
        @(negedge clk);

        // reset lands on the bit-4 edge of an in-flight operation
        a8 = 8'h44; b8 = 8'h99; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("midrst_busy8", busy8, 0);
        chk("midrst_done8", done8, 0);
        chk("midrst_diff8", diff8, 0);
        chk("midrst_bout8", bout8, 0);
        repeat (12) @(negedge clk);
        issue8(8'h9C, 8'h3A, 1'b1);
        repeat (2) @(negedge clk);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                issue4(4'(x), 4'(y));
            end
        end
        repeat (4) @(negedge clk);

        chk("done4_count", n_done4, 256);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
